option_streamer: RTL and testbench
==================================

Name: option_streamer

Overview:
- Sits directly upstream of the line solver.
- Holds the candidate-option queue for every row and column of a puzzle of up to SIZE×SIZE.
- Each round, streams each line as one index word followed by that line's surviving options, one per cycle.
- Re-enqueues only the options the solver flags as still consistent, and publishes the per-line option counts the solver consumes as old_options_amnt.

Parameters:
SIZE, 11, maximum rows/columns; lines = 2*SIZE
OPT_W, 16, width of one option / index word
DEPTH, 512, option queue entries (power of two)
CNT_W, 7, per-line option count width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
num_rows  in  4  active rows (1..SIZE)
num_cols  in  4  active columns (1..SIZE)
load_valid  in  1  load one option during LOAD
load_line  in  5  line index of loaded option (rows 0..num_rows-1, then columns)
load_data  in  OPT_W  option bit pattern
start  in  1  pulse: end loading, begin round 1
put_back  in  1  solver: keep option presented this cycle
solved  in  1  solver: puzzle fully known
option  out  OPT_W  index word or option to solver
option_valid  out  1  option bus carries a word
new_line  out  1  option bus carries a line index this cycle
started  out  1  one-cycle pulse when round 1 begins
old_options_amnt  out  2*SIZE×CNT_W  per-line counts for the current round
round_cnt  out  8  completed rounds
busy  out  1  not IDLE/LOAD/DONE
done  out  1  finished, sticky until reset
stuck  out  1  finished without solved (no progress)
overflow  out  1  load dropped because queue full, sticky

Behaviour:
- Reset: state IDLE, queue empty, all counts 0.
- Reset: option=0, option_valid=0, new_line=0, started=0, round_cnt=0, busy=0, done=0, stuck=0, overflow=0.
- Reset mid-operation aborts immediately to these values.
- IDLE→LOAD on the first load_valid.
- LOAD: each load_valid writes load_data at the queue tail and increments count[load_line].
- LOAD: options arrive grouped by line in ascending line order; the bench guarantees this.
- LOAD with the queue full: write dropped, overflow=1.
- LOAD/IDLE + start → INDEX with L=0, started=1 for one cycle. start while busy is ignored.
- Lines run 0..num_rows+num_cols-1.
- INDEX: option=L (zero-extended), option_valid=1, new_line=1 for exactly one cycle.
- INDEX: snapshot old_options_amnt ← count[] on the first line of each round.
- INDEX: newcnt=0. Next state is STREAM if count[L]>0, else NEXT.
- INDEX always emits, even for a zero-count line.
- STREAM: one option per cycle from the queue head, option_valid=1, new_line=0, exactly count[L] cycles.
- STREAM: when put_back=1 in the same cycle, that word is pushed to the tail and newcnt increments.
- STREAM: pop and push occur in the same cycle; occupancy never grows, so full is impossible here.
- NEXT: count[L]←newcnt. If count changed, set progress.
- NEXT: if L is the last line, go to ROUND_END; else L+1 → INDEX.
- ROUND_END: round_cnt+1 (saturating at 255).
- ROUND_END: solved=1 → DONE. progress=0 → DONE with stuck=1.
- ROUND_END: otherwise clear progress and go to INDEX with L=0.
- solved sampled anywhere in STREAM/INDEX is latched and honoured at ROUND_END.
- DONE: option_valid=0, done=1. Holds until reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Empty/full are derived from an extra occupancy counter.
- Latency: first index word appears the cycle after start.

Optional Feature:
- Macro OPT_STREAM_ROUND_LIMIT_EN.
- When defined: parameter MAX_ROUNDS (default 64). Reaching round_cnt==MAX_ROUNDS at ROUND_END without solved → DONE with stuck=1.
- When undefined: no limit; termination only by solved or no progress.

Decomposition:
- Package nonogram_pkg: SIZE, OPT_W, CNT_W, line-index type, the state enum (IDLE, LOAD, INDEX, STREAM, NEXT, ROUND_END, DONE), and the counts array type shared with the solver.
- Sub-module option_queue: circular buffer with simultaneous push/pop, occupancy, and full/empty flags.

Test Plan:
- Load 4×4 options (row1: 0011,0110,1100; row4: 1101; col2: 1000,0100,0010,0001), start → cycle after start: option=0, new_line=1; old_options_amnt[0]=3, [3]=1, [5]=4.
- Round 1, put_back for all but row4 1101 → round 2 streams index 3 for one cycle with zero options following; old_options_amnt[3]=0.
- put_back=1 on every option for a full round → ROUND_END sets done=1, stuck=1, round_cnt=1.
- solved pulsed mid-round 2 → remaining lines still streamed; done=1, stuck=0, round_cnt=2.
- Load DEPTH+1 options → overflow=1; queue holds DEPTH entries.
- Assert rst during STREAM → next edge: option_valid=0, busy=0, counts 0. A new load/start sequence then runs correctly.

Source files
------------

// File: rtl/nonogram_pkg.sv
// ============================================================================
// Module      : nonogram_pkg
// Description : Shared sizes, line-index/count types and streamer state
//               encoding used by the option streamer and the line solver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nonogram_pkg;

    localparam int SIZE   = 11;
    localparam int LINES  = 2 * SIZE;
    localparam int OPT_W  = 16;
    localparam int CNT_W  = 7;
    localparam int LINE_W = $clog2(LINES);

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef cnt_t [LINES-1:0]  counts_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        INDEX     = 3'd2,
        STREAM    = 3'd3,
        NEXT      = 3'd4,
        ROUND_END = 3'd5,
        DONE      = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/option_queue.sv
// ============================================================================
// Module      : option_queue
// Description : Circular option buffer with simultaneous push/pop; empty and
//               full come from an occupancy counter, pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module option_queue
    import nonogram_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = OPT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_occ;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_occ == '0);
    assign full      = (r_occ == (PTR_W+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A full queue may still accept a word when one leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/option_streamer.sv
// ============================================================================
// Module      : option_streamer
// Description : Holds per-line candidate options and streams them, round by
//               round, to the line solver, keeping only flagged survivors.
//               Optional round limit: define OPT_STREAM_ROUND_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module option_streamer
    import nonogram_pkg::*;
#(
    parameter int DEPTH      = 512
`ifdef OPT_STREAM_ROUND_LIMIT_EN
    ,
    parameter int MAX_ROUNDS = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       num_rows,
    input  logic [3:0]       num_cols,
    input  logic             load_valid,
    input  line_t            load_line,
    input  logic [OPT_W-1:0] load_data,
    input  logic             start,
    input  logic             put_back,
    input  logic             solved,
    output logic [OPT_W-1:0] option,
    output logic             option_valid,
    output logic             new_line,
    output logic             started,
    output counts_t          old_options_amnt,
    output logic [7:0]       round_cnt,
    output logic             busy,
    output logic             done,
    output logic             stuck,
    output logic             overflow
);

    state_t           r_state;
    state_t           w_state_next;
    line_t            r_line;
    line_t            w_last_line;
    counts_t          r_count;
    counts_t          r_old_amnt;
    cnt_t             r_newcnt;
    cnt_t             r_rem;
    logic             r_progress;
    logic             r_solved_l;
    logic             r_started;
    logic             r_stuck;
    logic             r_overflow;
    logic [7:0]       r_round_cnt;
    logic [7:0]       w_round_inc;
    logic             w_solved_any;
    logic             w_limit;
    logic             w_loading;
    logic             w_push;
    logic             w_pop;
    logic [OPT_W-1:0] w_wdata;
    logic [OPT_W-1:0] w_rdata;
    logic             w_full;
    logic             w_empty;

    option_queue #(
        .DEPTH (DEPTH),
        .WIDTH (OPT_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_last_line  = {1'b0, num_rows} + {1'b0, num_cols} - 5'd1;
    assign w_round_inc  = (r_round_cnt == 8'hFF) ? 8'hFF : r_round_cnt + 8'd1;
    assign w_solved_any = r_solved_l | solved;
    assign w_loading    = load_valid && !start && ((r_state == IDLE) || (r_state == LOAD));

`ifdef OPT_STREAM_ROUND_LIMIT_EN
    assign w_limit = (w_round_inc == 8'(MAX_ROUNDS));
`else
    assign w_limit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = INDEX;
                end else if (load_valid) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (start) begin
                    w_state_next = INDEX;
                end
            end
            INDEX:     w_state_next = (r_count[r_line] != '0) ? STREAM : NEXT;
            STREAM:    w_state_next = (r_rem == cnt_t'(1)) ? NEXT : STREAM;
            NEXT:      w_state_next = (r_line == w_last_line) ? ROUND_END : INDEX;
            ROUND_END: w_state_next = (w_solved_any || !r_progress || w_limit) ? DONE : INDEX;
            DONE:      w_state_next = DONE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        option       = '0;
        option_valid = 1'b0;
        new_line     = 1'b0;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_wdata      = load_data;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE, LOAD: begin
                busy   = 1'b0;
                w_push = w_loading;
            end
            INDEX: begin
                option       = {{(OPT_W-LINE_W){1'b0}}, r_line};
                option_valid = 1'b1;
                new_line     = 1'b1;
            end
            STREAM: begin
                // Survivors go straight back to the tail as they leave the head.
                option       = w_rdata;
                option_valid = 1'b1;
                w_pop        = !w_empty;
                w_push       = put_back;
                w_wdata      = w_rdata;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line      <= '0;
            r_count     <= '0;
            r_old_amnt  <= '0;
            r_newcnt    <= '0;
            r_rem       <= '0;
            r_progress  <= 1'b0;
            r_solved_l  <= 1'b0;
            r_started   <= 1'b0;
            r_stuck     <= 1'b0;
            r_overflow  <= 1'b0;
            r_round_cnt <= '0;
        end else begin
            r_started <= 1'b0;
            case (r_state)
                IDLE, LOAD: begin
                    if (start) begin
                        r_started  <= 1'b1;
                        r_line     <= '0;
                        r_old_amnt <= r_count;
                        r_progress <= 1'b0;
                        r_solved_l <= 1'b0;
                    end else if (load_valid) begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count[load_line] <= r_count[load_line] + 1'b1;
                        end
                    end
                end
                INDEX: begin
                    r_newcnt <= '0;
                    r_rem    <= r_count[r_line];
                    if (solved) begin
                        r_solved_l <= 1'b1;
                    end
                end
                STREAM: begin
                    r_rem <= r_rem - 1'b1;
                    if (put_back) begin
                        r_newcnt <= r_newcnt + 1'b1;
                    end
                    if (solved) begin
                        r_solved_l <= 1'b1;
                    end
                end
                NEXT: begin
                    r_count[r_line] <= r_newcnt;
                    if (r_newcnt != r_count[r_line]) begin
                        r_progress <= 1'b1;
                    end
                    if (r_line != w_last_line) begin
                        r_line <= r_line + 1'b1;
                    end
                end
                ROUND_END: begin
                    r_round_cnt <= w_round_inc;
                    if (w_state_next == DONE) begin
                        r_stuck <= !w_solved_any;
                    end else begin
                        r_progress <= 1'b0;
                        r_solved_l <= 1'b0;
                        r_line     <= '0;
                        r_old_amnt <= r_count;
                    end
                end
                default: ;
            endcase
        end
    end

    assign started          = r_started;
    assign old_options_amnt = r_old_amnt;
    assign round_cnt        = r_round_cnt;
    assign stuck            = r_stuck;
    assign overflow         = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_option_streamer.sv
// ============================================================================
// Module      : tb_option_streamer
// Description : Directed, table-driven bench for option_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_option_streamer;
    import nonogram_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       num_rows = 4'd4;
    logic [3:0]       num_cols = 4'd4;
    logic             load_valid = 1'b0;
    line_t            load_line = '0;
    logic [OPT_W-1:0] load_data = '0;
    logic             start = 1'b0;
    logic             put_back = 1'b0;
    logic             solved = 1'b0;
    logic [OPT_W-1:0] option;
    logic             option_valid;
    logic             new_line;
    logic             started;
    counts_t          old_amnt;
    logic [7:0]       round_cnt;
    logic             busy;
    logic             done;
    logic             stuck;
    logic             overflow;

    always #5 clk = ~clk;

    option_streamer #(.DEPTH(512)) dut (
        .clk              (clk),
        .rst              (rst),
        .num_rows         (num_rows),
        .num_cols         (num_cols),
        .load_valid       (load_valid),
        .load_line        (load_line),
        .load_data        (load_data),
        .start            (start),
        .put_back         (put_back),
        .solved           (solved),
        .option           (option),
        .option_valid     (option_valid),
        .new_line         (new_line),
        .started          (started),
        .old_options_amnt (old_amnt),
        .round_cnt        (round_cnt),
        .busy             (busy),
        .done             (done),
        .stuck            (stuck),
        .overflow         (overflow)
    );

    typedef struct {
        logic        pb;
        logic        sv;
        logic [15:0] opt;
        logic        vld;
        logic        nl;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load(input int l, input logic [15:0] d);
        load_valid = 1'b1;
        load_line  = line_t'(l);
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // 4x4 puzzle: row1 -> line 0, row4 -> line 3, col2 -> line 5
    task automatic load_4x4();
        num_rows = 4'd4;
        num_cols = 4'd4;
        load(0, 16'h0003); load(0, 16'h0006); load(0, 16'h000C);
        load(3, 16'h000D);
        load(5, 16'h0008); load(5, 16'h0004); load(5, 16'h0002); load(5, 16'h0001);
    endtask

    task automatic add(input logic pb, input logic sv, input logic [15:0] o,
                       input logic v, input logic nl);
        vec_t e;
        e.pb = pb; e.sv = sv; e.opt = o; e.vld = v; e.nl = nl;
        tbl.push_back(e);
    endtask

    // One round of the 4x4 puzzle: INDEX, options, NEXT per line, then ROUND_END.
    task automatic build_round(input bit has_d, input bit pb_d, input int solve_at);
        tbl.delete();
        for (int l = 0; l < 8; l++) begin
            add(1'b0, 1'b0, 16'(l), 1'b1, 1'b1);
            if (l == 0) begin
                add(1'b1, 1'b0, 16'h3, 1'b1, 1'b0);
                add(1'b1, 1'b0, 16'h6, 1'b1, 1'b0);
                add(1'b1, 1'b0, 16'hC, 1'b1, 1'b0);
            end
            if (l == 3 && has_d) add(pb_d, 1'b0, 16'hD, 1'b1, 1'b0);
            if (l == 5) begin
                add(1'b1, 1'b0, 16'h8, 1'b1, 1'b0);
                add(1'b1, 1'b0, 16'h4, 1'b1, 1'b0);
                add(1'b1, 1'b0, 16'h2, 1'b1, 1'b0);
                add(1'b1, 1'b0, 16'h1, 1'b1, 1'b0);
            end
            add(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        end
        add(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        if (solve_at >= 0) tbl[solve_at].sv = 1'b1;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            chk($sformatf("%s[%0d] bus", tag, i), 32'({option, option_valid, new_line}),
                32'({tbl[i].opt, tbl[i].vld, tbl[i].nl}));
            put_back = tbl[i].pb;
            solved   = tbl[i].sv;
            tick();
        end
        put_back = 1'b0;
        solved   = 1'b0;
    endtask

    task automatic run_stuck(input string tag);
        load_4x4();
        do_start();
        build_round(1'b1, 1'b1, -1);
        run_table(tag);
        chk({tag, " done"},      32'(done),         32'd1);
        chk({tag, " stuck"},     32'(stuck),        32'd1);
        chk({tag, " round_cnt"}, 32'(round_cnt),    32'd1);
        chk({tag, " valid"},     32'(option_valid), 32'd0);
        chk({tag, " busy"},      32'(busy),         32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset option",   32'(option),       32'd0);
        chk("reset valid",    32'(option_valid), 32'd0);
        chk("reset new_line", 32'(new_line),     32'd0);
        chk("reset started",  32'(started),      32'd0);
        chk("reset status",   32'({round_cnt, busy, done, stuck, overflow}), 32'd0);
        chk("reset counts",   32'(old_amnt[5]),  32'd0);

        // Round 1 drops 1101 from line 3; round 2 is all put_back with solved mid-round.
        load_4x4();
        chk("load busy", 32'(busy), 32'd0);
        do_start();
        chk("started pulse", 32'(started),     32'd1);
        chk("r1 amnt[0]",    32'(old_amnt[0]), 32'd3);
        chk("r1 amnt[3]",    32'(old_amnt[3]), 32'd1);
        chk("r1 amnt[5]",    32'(old_amnt[5]), 32'd4);
        chk("r1 busy",       32'(busy),        32'd1);
        build_round(1'b1, 1'b0, -1);
        run_table("r1");
        chk("started low",   32'(started),     32'd0);
        chk("r2 amnt[0]",    32'(old_amnt[0]), 32'd3);
        chk("r2 amnt[3]",    32'(old_amnt[3]), 32'd0);
        chk("r2 amnt[5]",    32'(old_amnt[5]), 32'd4);
        chk("r2 round_cnt",  32'(round_cnt),   32'd1);
        build_round(1'b0, 1'b1, 15);
        run_table("r2");
        chk("solved done",      32'(done),         32'd1);
        chk("solved stuck",     32'(stuck),        32'd0);
        chk("solved round_cnt", 32'(round_cnt),    32'd2);
        chk("solved valid",     32'(option_valid), 32'd0);
        tick();
        tick();
        chk("done sticky",      32'(done),         32'd1);

        do_reset();
        run_stuck("stuck1");

        // Fill 512 entries over all 22 lines, then one more that must be dropped.
        do_reset();
        num_rows = 4'd11;
        num_cols = 4'd11;
        for (int l = 0; l < 22; l++) begin
            for (int k = 0; k < ((l < 21) ? 24 : 9); k++) begin
                if (l == 21 && k == 8) chk("ovf before full", 32'(overflow), 32'd0);
                load(l, 16'(l * 256 + k + 1));
            end
        end
        chk("ovf set", 32'(overflow), 32'd1);
        do_start();
        chk("ovf amnt[0]",  32'(old_amnt[0]),  32'd24);
        chk("ovf amnt[20]", 32'(old_amnt[20]), 32'd24);
        chk("ovf amnt[21]", 32'(old_amnt[21]), 32'd8);
        chk("ovf index0",   32'({option, option_valid, new_line}), 32'({16'h0, 1'b1, 1'b1}));
        tick();
        chk("ovf first opt", 32'({option, option_valid, new_line}), 32'({16'h0001, 1'b1, 1'b0}));

        // Reset while streaming, then a fresh session.
        rst = 1'b1;
        tick();
        chk("rst valid",    32'(option_valid), 32'd0);
        chk("rst busy",     32'(busy),         32'd0);
        chk("rst counts",   32'(old_amnt[0]),  32'd0);
        chk("rst overflow", 32'(overflow),     32'd0);
        chk("rst round",    32'(round_cnt),    32'd0);
        rst = 1'b0;
        tick();
        run_stuck("stuck2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
